mac_pipeline: RTL and testbench
===============================

// Module: mac_pipeline
// PURPOSE
//   Two-stage pipelined signed multiply-accumulate: y = acc + a*b.
//   - Datapath leaf of the toy accelerator PE array; fed by the operand/accumulator scheduler.
//   - Fully pipelined: accepts one operation per cycle, no back-pressure.
// PARAMETERS
//   DATA_W  8   width of signed operands a, b
//   ACC_W   32  width of signed accumulator input acc and result y (ACC_W >= 2*DATA_W)
// PORTS
//   clk        in   1       rising-edge clock
//   rst_n      in   1       asynchronous active-low reset
//   in_valid   in   1       a/b/acc valid this cycle; sampled every clk edge
//   a          in   DATA_W  signed multiplicand
//   b          in   DATA_W  signed multiplier
//   acc        in   ACC_W   signed addend
//   out_valid  out  1       y holds a new result this cycle
//   y          out  ACC_W   signed result acc + a*b
// BEHAVIOUR
//   - Reset (rst_n low, asynchronous assert, synchronous release):
//     - all valid flags = 0; all data registers = 0; out_valid = 0; y = 0.
//   - Stage 1, edge N with in_valid = 1:
//     - register prod = a*b, signed, 2*DATA_W bits;
//     - register acc alongside prod;
//     - set v1 = 1.
//   - Stage 2, edge N+1 with v1 = 1:
//     - register y = acc + sign-extended prod, ACC_W bits;
//     - set out_valid = 1.
//   - Latency is exactly 2 clock edges.
//     - Input sampled at edge N appears on y/out_valid after edge N+1.
//   - Throughput is 1 op/cycle.
//     - Back-to-back in_valid gives back-to-back out_valid, in issue order.
//     - No reordering, no drops.
//   - in_valid = 0:
//     - the stage's valid flag clears;
//     - its data registers hold their previous value (no load);
//     - y holds the last result while out_valid = 0.
//   - out_valid is high for exactly one cycle per accepted input.
//   - Overflow (default): the ACC_W addition wraps modulo 2^ACC_W, two's complement.
//   - The product never overflows: it is 2*DATA_W bits and exact.
//   - Reset mid-operation flushes every in-flight op; no out_valid appears for it afterwards.
//   - Operands are X-tolerant when in_valid = 0: they are not registered.
// CONFIGURATION
//   MAC_SATURATE_EN defined:
//     - on signed overflow of acc + prod, y clamps to +(2^(ACC_W-1)-1) or -(2^(ACC_W-1));
//     - latency is unchanged.
//   MAC_SATURATE_EN undefined:
//     - wrap-around addition as above;
//     - no saturation logic is generated.
// STRUCTURE
//   - Package mac_pkg:
//     - DATA_W/ACC_W default constants;
//     - PROD_W = 2*DATA_W;
//     - typedefs operand_t, prod_t, acc_t;
//     - function sat_add(acc_t, acc_t) returning acc_t (used only under MAC_SATURATE_EN).
//   - Sub-module mac_mult_stage:
//     - stage-1 register slice: valid flag, prod and acc pass-through;
//     - mac_pipeline instantiates it and implements stage 2 (add, optional saturation, output registers).
// TESTING
//   1. Reset:
//      - rst_n low 2 cycles -> out_valid = 0, y = 0.
//      - Release rst_n -> out_valid stays 0 with in_valid = 0.
//   2. Back-to-back issue: (a,b,acc) = (3,4,10), (-2,7,5), (8,8,0) on 3 consecutive cycles.
//      - Expect 3 consecutive out_valid pulses with y = 22, -9, 64.
//      - First pulse 2 edges after the first issue.
//   3. Sign extremes:
//      - (-128,-128,0) -> 16384.
//      - (-128,127,0) -> -16256.
//      - (127,127,-1) -> 16128.
//   4. Overflow, acc = 2147483647, a = 1, b = 1:
//      - default build: y = -2147483648;
//      - MAC_SATURATE_EN build: y = 2147483647.
//   5. Gapped issue: one valid op, 3 idle cycles, one valid op.
//      - Exactly 2 out_valid pulses, 4 cycles apart.
//      - y holds its value between the pulses.
//   6. Reset mid-flight: issue (5,5,0), assert rst_n low after 1 edge.
//      - No out_valid; y = 0 after reset.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types and constants for the pipelined signed multiply-accumulate.
// sat_add is only referenced when MAC_SATURATE_EN is defined.
package mac_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ACC_W  = 32;
    localparam int PROD_W     = 2 * DEF_DATA_W;

    typedef logic signed [DEF_DATA_W-1:0] operand_t;
    typedef logic signed [PROD_W-1:0]     prod_t;
    typedef logic signed [DEF_ACC_W-1:0]  acc_t;

    // Overflow is only possible when both addends share a sign and the sum flips it.
    function automatic acc_t sat_add(input acc_t x, input acc_t z);
        acc_t s;
        s = x + z;
        if ((x[DEF_ACC_W-1] == z[DEF_ACC_W-1]) && (s[DEF_ACC_W-1] != x[DEF_ACC_W-1])) begin
            s = x[DEF_ACC_W-1] ? {1'b1, {(DEF_ACC_W-1){1'b0}}}
                               : {1'b0, {(DEF_ACC_W-1){1'b1}}};
        end
        return s;
    endfunction

endpackage

// File: rtl/mac_mult_stage.sv
// First pipeline stage: exact signed product of a*b with the addend carried alongside.
// Data registers load only on a valid input, so idle operands are never captured.
module mac_mult_stage
    import mac_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid_i,
    input  logic signed [DATA_W-1:0]   a_i,
    input  logic signed [DATA_W-1:0]   b_i,
    input  logic signed [ACC_W-1:0]    acc_i,
    output logic                       vld_p1_o,
    output logic signed [2*DATA_W-1:0] prod_p1_o,
    output logic signed [ACC_W-1:0]    acc_p1_o
);

    localparam int MUL_W = 2 * DATA_W;

    logic signed [MUL_W-1:0] a_ext;
    logic signed [MUL_W-1:0] b_ext;
    logic signed [MUL_W-1:0] prod_p1_d;

    logic                    vld_p1_q;
    logic signed [MUL_W-1:0] prod_p1_q;
    logic signed [ACC_W-1:0] acc_p1_q;

    assign a_ext     = MUL_W'(a_i);
    assign b_ext     = MUL_W'(b_i);
    assign prod_p1_d = a_ext * b_ext;

    // ---- stage 1 boundary ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q  <= 1'b0;
            prod_p1_q <= '0;
            acc_p1_q  <= '0;
        end else begin
            vld_p1_q <= in_valid_i;
            if (in_valid_i) begin
                prod_p1_q <= prod_p1_d;
                acc_p1_q  <= acc_i;
            end
        end
    end

    assign vld_p1_o  = vld_p1_q;
    assign prod_p1_o = prod_p1_q;
    assign acc_p1_o  = acc_p1_q;

endmodule

// File: rtl/mac_pipeline.sv
// Two-stage pipelined signed MAC, y = acc + a*b, one op per cycle, latency 2 edges.
// Define MAC_SATURATE_EN to clamp on signed overflow instead of wrapping.
module mac_pipeline
    import mac_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    input  logic signed [ACC_W-1:0]  acc,
    output logic                     out_valid,
    output logic signed [ACC_W-1:0]  y
);

    localparam int MUL_W = 2 * DATA_W;

    logic                    vld_p1;
    logic signed [MUL_W-1:0] prod_p1;
    logic signed [ACC_W-1:0] acc_p1;

    logic signed [ACC_W-1:0] prod_ext_p1;
    logic signed [ACC_W-1:0] y_p2_d;

    logic                    vld_p2_q;
    logic signed [ACC_W-1:0] y_p2_q;

    mac_mult_stage #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mult (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid_i (in_valid),
        .a_i        (a),
        .b_i        (b),
        .acc_i      (acc),
        .vld_p1_o   (vld_p1),
        .prod_p1_o  (prod_p1),
        .acc_p1_o   (acc_p1)
    );

    assign prod_ext_p1 = ACC_W'(prod_p1);

`ifdef MAC_SATURATE_EN
    assign y_p2_d = sat_add(acc_t'(acc_p1), acc_t'(prod_ext_p1));
`else
    assign y_p2_d = acc_p1 + prod_ext_p1;
`endif

    // ---- stage 2 boundary ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2_q <= 1'b0;
            y_p2_q   <= '0;
        end else begin
            vld_p2_q <= vld_p1;
            if (vld_p1) begin
                y_p2_q <= y_p2_d;
            end
        end
    end

    assign out_valid = vld_p2_q;
    assign y         = y_p2_q;

endmodule

// File: tb/tb_mac_pipeline.sv
// Scoreboard bench for mac_pipeline: directed cases plus randomized traffic against
// an arithmetic reference model (honours MAC_SATURATE_EN).
module tb_mac_pipeline;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic signed [7:0]  a;
    logic signed [7:0]  b;
    logic signed [31:0] acc;
    logic               out_valid;
    logic signed [31:0] y;

    mac_pipeline #(.DATA_W(8), .ACC_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .acc       (acc),
        .out_valid (out_valid),
        .y         (y)
    );

    typedef struct {
        logic signed [31:0] y;
        int                 sedge;
    } exp_t;

    exp_t               sb_q[$];
    int                 cyc = 0;
    int                 n_checks = 0;
    int                 n_pass = 0;
    int                 n_out = 0;
    int                 n_pushed = 0;
    logic signed [31:0] last_y = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: exact integer arithmetic, then wrap or clamp to 32 bits.
    function automatic logic signed [31:0] model(input int ia, input int ib, input longint iacc);
        longint s;
        s = iacc + longint'(ia) * longint'(ib);
`ifdef MAC_SATURATE_EN
        if (s > 64'sd2147483647)  s = 64'sd2147483647;
        if (s < -64'sd2147483648) s = -64'sd2147483648;
`endif
        return s[31:0];
    endfunction

    task automatic issue(input int ia, input int ib, input longint iacc, input bit push);
        exp_t e;
        @(posedge clk); #1;
        in_valid = 1'b1;
        a        = 8'(ia);
        b        = 8'(ib);
        acc      = 32'(iacc);
        if (push) begin
            e.y     = model(ia, ib, iacc);
            e.sedge = cyc + 1;
            sb_q.push_back(e);
            n_pushed++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            a        = 8'($urandom);
            b        = 8'($urandom);
            acc      = 32'($urandom);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            last_y = '0;
        end else if (out_valid) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_out_valid", 1, 0);
            end else begin
                e = sb_q.pop_front();
                chk("y", y, e.y);
                chk("latency", cyc - e.sedge, 1);
                n_out++;
            end
            last_y = y;
        end else begin
            chk("y_hold", y, last_y);
        end
    end

    initial begin
        logic signed [7:0]  ra;
        logic signed [7:0]  rb;
        logic signed [31:0] racc;
        int                 guard;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        acc      = '0;

        // Reset state
        repeat (2) begin
            @(negedge clk);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_y", y, 0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(3);

        // Back-to-back issue
        issue(3, 4, 10, 1'b1);
        issue(-2, 7, 5, 1'b1);
        issue(8, 8, 0, 1'b1);
        idle(4);

        // Sign extremes
        issue(-128, -128, 0, 1'b1);
        issue(-128, 127, 0, 1'b1);
        issue(127, 127, -1, 1'b1);
        idle(3);

        // Overflow at the positive limit, and the negative limit
        issue(1, 1, 64'sd2147483647, 1'b1);
        issue(-128, 127, -64'sd2147483648, 1'b1);
        idle(3);

        // Gapped issue
        issue(9, -3, 100, 1'b1);
        idle(3);
        issue(-7, -7, -50, 1'b1);
        idle(4);

        // Reset mid-flight: the op must vanish
        issue(5, 5, 0, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("midrst_out_valid", out_valid, 0);
            chk("midrst_y", y, 0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(4);

        // Randomized traffic, with addends biased toward the overflow edges
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                ra   = 8'($urandom);
                rb   = 8'($urandom);
                racc = 32'($urandom);
                case ($urandom_range(0, 3))
                    0: racc = 32'sh7FFF_C000 + 32'($urandom_range(0, 16'hFFFF));
                    1: racc = 32'sh8000_0000 + 32'($urandom_range(0, 16'hFFFF));
                    default: ;
                endcase
                issue(int'(ra), int'(rb), longint'(racc), 1'b1);
            end else begin
                idle($urandom_range(1, 3));
            end
        end
        idle(1);

        guard = 0;
        while (sb_q.size() != 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        chk("drain_pending", sb_q.size(), 0);
        chk("result_count", n_out, n_pushed);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, pending %0d", sb_q.size());
        $fatal(1, "watchdog");
    end

endmodule
